data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory for an RV32I core. After reset it runs a clear walk over all words.
// Optional macro DMEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of forcing them aligned.
module data_memory_ctrl #(
   parameter int DEPTH_WORDS = 64,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] Write_Data,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [2:0]  funct3,
   output logic [31:0] Data_out,
   output logic        busy,
   output logic        misalign_fault
);

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;
   logic [31:0]      mem_q [DEPTH_WORDS];

   logic [IDX_W-1:0] idx_s;
   logic [1:0]       off_s;
   logic [31:0]      rd_word_s;
   logic [7:0]       rd_byte_s;
   logic [15:0]      rd_half_s;
   logic [31:0]      load_val_s;
   logic [3:0]       be_s;
   logic [31:0]      wdata_s;
   logic             store_en_s;
   logic             load_kill_s;
   logic             store_kill_s;
   logic             unused_addr_s;

   assign idx_s         = Address[IDX_W+1:2];
   assign unused_addr_s = ^Address[31:IDX_W+2];
   assign busy          = (state_q == CLEAR);

   // Effective lane offset: halfword/word accesses are forced onto their natural boundary
   always_comb begin
      off_s = Address[1:0];
      case (funct3[1:0])
         2'b01:   off_s = {Address[1], 1'b0};
         2'b10:   off_s = 2'b00;
         default: off_s = Address[1:0];
      endcase
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   logic load_mis_s;
   logic store_mis_s;
   logic fault_q, fault_d;

   assign load_mis_s  = (((funct3 == 3'b001) || (funct3 == 3'b101)) && Address[0]) ||
                        ((funct3 == 3'b010) && (Address[1:0] != 2'b00));
   assign store_mis_s = ((funct3 == 3'b001) && Address[0]) ||
                        ((funct3 == 3'b010) && (Address[1:0] != 2'b00));
   assign load_kill_s    = load_mis_s;
   assign store_kill_s   = store_mis_s;
   assign misalign_fault = fault_q;

   // Sticky fault: set by any misaligned request while READY
   always_comb begin
      fault_d = fault_q;
      if ((state_q == READY) && ((MemRead && load_mis_s) || (MemWrite && store_mis_s))) begin
         fault_d = 1'b1;
      end else begin
         fault_d = fault_q;
      end
   end

   // Fault register
   always_ff @(posedge clk) begin
      if (reset) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end
`else
   assign load_kill_s    = 1'b0;
   assign store_kill_s   = 1'b0;
   assign misalign_fault = 1'b0;
`endif

   // FSM next state: CLEAR walks every word once, then READY is held until reset
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      case (state_q)
         CLEAR: begin
            clr_ptr_d = clr_ptr_q + IDX_W'(1);
            if (clr_ptr_q == IDX_W'(DEPTH_WORDS - 1)) begin
               state_d = READY;
            end else begin
               state_d = CLEAR;
            end
         end
         READY:   state_d = READY;
         default: state_d = CLEAR;
      endcase
   end

   // FSM state and clear pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CLEAR;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   assign rd_word_s = mem_q[idx_s];
   assign rd_byte_s = rd_word_s[{off_s, 3'b000} +: 8];
   assign rd_half_s = off_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];

   // Load extraction and extension; output reads the array before any same-cycle store
   always_comb begin
      load_val_s = 32'h0;
      case (funct3)
         3'b000:  load_val_s = {{24{rd_byte_s[7]}}, rd_byte_s};
         3'b001:  load_val_s = {{16{rd_half_s[15]}}, rd_half_s};
         3'b010:  load_val_s = rd_word_s;
         3'b100:  load_val_s = {24'h0, rd_byte_s};
         3'b101:  load_val_s = {16'h0, rd_half_s};
         default: load_val_s = 32'h0;
      endcase
      if (MemRead && (state_q == READY) && !load_kill_s) begin
         Data_out = load_val_s;
      end else begin
         Data_out = 32'h0;
      end
   end

   // Store lane enables with data replicated across lanes
   always_comb begin
      be_s    = 4'b0000;
      wdata_s = Write_Data;
      case (funct3)
         3'b000: begin
            be_s    = 4'b0001 << off_s;
            wdata_s = {4{Write_Data[7:0]}};
         end
         3'b001: begin
            be_s    = off_s[1] ? 4'b1100 : 4'b0011;
            wdata_s = {2{Write_Data[15:0]}};
         end
         3'b010: begin
            be_s    = 4'b1111;
            wdata_s = Write_Data;
         end
         default: begin
            be_s    = 4'b0000;
            wdata_s = Write_Data;
         end
      endcase
   end

   assign store_en_s = MemWrite && (state_q == READY) && !reset && !store_kill_s;

   // Array: the clear walk has priority; stores only land in READY
   always_ff @(posedge clk) begin
      if (!reset && (state_q == CLEAR)) begin
         mem_q[clr_ptr_q] <= 32'h0;
      end else if (store_en_s) begin
         for (int n = 0; n < 4; n++) begin
            if (be_s[n]) begin
               mem_q[idx_s][8*n +: 8] <= wdata_s[8*n +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomized bench for data_memory_ctrl against a byte-array reference model.
module tb_data_memory_ctrl;

   localparam int DEPTH = 64;
   localparam int NB    = DEPTH * 4;
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] Write_Data;
   logic        MemWrite;
   logic        MemRead;
   logic [2:0]  funct3;
   logic [31:0] Data_out;
   logic        busy;
   logic        misalign_fault;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mb [NB];
   bit         m_busy;
   int         m_clr;
   bit         m_fault;

   always #5 clk = ~clk;

   data_memory_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .Address        (Address),
      .Write_Data     (Write_Data),
      .MemWrite       (MemWrite),
      .MemRead        (MemRead),
      .funct3         (funct3),
      .Data_out       (Data_out),
      .busy           (busy),
      .misalign_fault (misalign_fault)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic bit is_mis(input logic [2:0] f3, input int a, input bit ld);
      if (f3 == 3'd1 || (ld && f3 == 3'd5)) return (a % 2) != 0;
      if (f3 == 3'd2) return (a % 4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [2:0] f3);
      int a = int'(addr % NB);
      int h = a - (a % 2);
      int w = a - (a % 4);
      logic [15:0] hv = {mb[h+1], mb[h]};
      if (TRAP && is_mis(f3, a, 1'b1)) return 32'h0;
      case (f3)
         3'd0:    return {{24{mb[a][7]}}, mb[a]};
         3'd1:    return {{16{hv[15]}}, hv};
         3'd2:    return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
         3'd4:    return {24'h0, mb[a]};
         3'd5:    return {16'h0, hv};
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_edge(input logic rst, input logic we, input logic re,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
      int a = int'(addr % NB);
      int h = a - (a % 2);
      int w = a - (a % 4);
      if (rst) begin
         m_busy  = 1'b1;
         m_clr   = 0;
         m_fault = 1'b0;
      end else if (m_busy) begin
         for (int k = 0; k < 4; k++) mb[m_clr*4 + k] = 8'h00;
         m_clr++;
         if (m_clr == DEPTH) m_busy = 1'b0;
      end else begin
         if (TRAP && ((re && is_mis(f3, a, 1'b1)) || (we && is_mis(f3, a, 1'b0)))) m_fault = 1'b1;
         if (we && !(TRAP && is_mis(f3, a, 1'b0))) begin
            case (f3)
               3'd0: mb[a] = wd[7:0];
               3'd1: begin mb[h] = wd[7:0]; mb[h+1] = wd[15:8]; end
               3'd2: for (int k = 0; k < 4; k++) mb[w+k] = wd[8*k +: 8];
               default: ;
            endcase
         end
      end
   endtask

   task automatic do_cycle(input logic rst, input logic we, input logic re,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3,
                           output logic [31:0] obs);
      logic [31:0] exp;
      reset = rst; MemWrite = we; MemRead = re; Address = addr; Write_Data = wd; funct3 = f3;
      #4;
      obs = Data_out;
      exp = (m_busy || !re) ? 32'h0 : m_load(addr, f3);
      check_val("data_out", obs, exp);
      check_val("busy", 32'(busy), 32'(m_busy));
      check_val("fault", 32'(misalign_fault), 32'(m_fault));
      @(posedge clk);
      m_edge(rst, we, re, addr, wd, f3);
      #1;
   endtask

   task automatic rand_cycle();
      logic [31:0] obs;
      logic [31:0] addr = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom % NB);
      do_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom,
               3'($urandom_range(0, 7)), obs);
   endtask

   task automatic st(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
      logic [31:0] obs;
      do_cycle(1'b0, 1'b1, 1'b0, addr, wd, f3, obs);
   endtask

   task automatic ld(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                     input logic [31:0] exp);
      logic [31:0] obs;
      do_cycle(1'b0, 1'b0, 1'b1, addr, 32'h0, f3, obs);
      check_val(tag, obs, exp);
   endtask

   // Runs the clear walk; optionally injects a SW of CAFEF00D to word 0 at walk cycle st_at
   task automatic run_clear(input string tag, input int st_at);
      logic [31:0] obs;
      int cnt = 0;
      while (busy && cnt < 200) begin
         if (cnt == st_at) do_cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'hCAFEF00D, 3'd2, obs);
         else rand_cycle();
         cnt++;
      end
      check_val(tag, 32'(cnt), 32'(DEPTH));
   endtask

   initial begin
      logic [31:0] obs;
      reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
      Address = 32'h0; Write_Data = 32'h0; funct3 = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      m_busy = 1'b1; m_clr = 0; m_fault = 1'b0;

      // Reset held: busy and zero output regardless of request
      do_cycle(1'b1, 1'b1, 1'b1, 32'h10, 32'h1234, 3'd2, obs);
      do_cycle(1'b1, 1'b0, 1'b1, 32'h14, 32'h0, 3'd2, obs);
      run_clear("busy_len_first", -1);

      for (int i = 0; i < 4; i++) ld("lw_zero", $urandom, 3'd2, 32'h0);

      st(32'h10, 32'h11223344, 3'd2);
      ld("lb_13", 32'h13, 3'd0, 32'h00000011);
      ld("lh_12", 32'h12, 3'd1, 32'h00001122);
      ld("lbu_10", 32'h10, 3'd4, 32'h00000044);

      st(32'h20, 32'h000080FF, 3'd2);
      st(32'h21, 32'h000000AA, 3'd0);
      ld("lh_20", 32'h20, 3'd1, 32'hFFFFAAFF);
      ld("lhu_20", 32'h20, 3'd5, 32'h0000AAFF);

      do_cycle(1'b0, 1'b1, 1'b1, 32'h40, 32'h12345678, 3'd2, obs);
      check_val("same_cycle_old", obs, 32'h0);
      ld("same_cycle_new", 32'h40, 3'd2, 32'h12345678);

      st(32'h06, 32'hDEADBEEF, 3'd2);
      check_val("mis_fault", 32'(misalign_fault), TRAP ? 32'h1 : 32'h0);
      ld("mis_lw_04", 32'h04, 3'd2, TRAP ? 32'h0 : 32'hDEADBEEF);

      st(32'h100, 32'h5A5A5A5A, 3'd2);
      ld("alias_lw_0", 32'h0, 3'd2, 32'h5A5A5A5A);

      for (int i = 0; i < 400; i++) rand_cycle();

      // Reset mid-walk restarts; a store during the walk is dropped
      st(32'h0, 32'h77777777, 3'd2);
      do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, obs);
      for (int i = 0; i < 30; i++) rand_cycle();
      do_cycle(1'b1, 1'b1, 1'b0, 32'h8, 32'h99999999, 3'd2, obs);
      run_clear("busy_len_restart", 40);
      ld("dropped_store_w0", 32'h0, 3'd2, 32'h0);

      for (int i = 0; i < 200; i++) rand_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
